// File: rtl/sprite_fsm.sv
// Sprite-attribute fetch sequencer: walks eight sprites per vblank, reading four bytes each.
// Define SPRITE_FSM_PALETTE_OUT_EN to build the packed palette_out register; otherwise it reads 0.
module sprite_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblank,
    input  logic [7:0]  sprite_RAM_din,
    output logic        rd_en,
    output logic [15:0] sprite_RAM_addr,
    output logic [7:0]  fsm_dout,
    output logic [7:0]  ld_palette,
    output logic [7:0]  ld_x,
    output logic [7:0]  ld_y,
    output logic [7:0]  ld_num_flips,
    output logic [31:0] palette_out
);

    typedef enum logic [2:0] {
        IDLE,
        PAL_ADDR,
        GET_X,
        GET_Y,
        GET_SPRITE,
        NEXT_SPRITE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic [15:0] w_off;
    logic [7:0]  w_onehot;

    assign w_off    = {12'h000, r_idx, 1'b0};
    assign w_onehot = 8'b0000_0001 << r_idx;
    assign fsm_dout = sprite_RAM_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE)
                r_idx <= '0;
            else if (r_state == NEXT_SPRITE && r_idx != 3'd7)
                r_idx <= r_idx + 3'd1;
        end
    end

    always_comb begin
        w_next          = r_state;
        rd_en           = 1'b0;
        sprite_RAM_addr = '0;
        ld_palette      = '0;
        ld_x            = '0;
        ld_y            = '0;
        ld_num_flips    = '0;
        case (r_state)
            IDLE: begin
                if (vblank)
                    w_next = PAL_ADDR;
            end
            PAL_ADDR: begin
                rd_en           = 1'b1;
                sprite_RAM_addr = 16'h4FF1 + w_off;
                w_next          = GET_X;
            end
            GET_X: begin
                rd_en           = 1'b1;
                sprite_RAM_addr = 16'h5060 + w_off;
                ld_palette      = w_onehot;
                w_next          = GET_Y;
            end
            GET_Y: begin
                rd_en           = 1'b1;
                sprite_RAM_addr = 16'h5061 + w_off;
                ld_x            = w_onehot;
                w_next          = GET_SPRITE;
            end
            GET_SPRITE: begin
                rd_en           = 1'b1;
                sprite_RAM_addr = 16'h4FF0 + w_off;
                ld_y            = w_onehot;
                w_next          = NEXT_SPRITE;
            end
            NEXT_SPRITE: begin
                ld_num_flips = w_onehot;
                w_next       = (r_idx == 3'd7) ? DONE : PAL_ADDR;
            end
            DONE: begin
                // Held here while vblank stays high so only one pass runs per blank.
                if (!vblank)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef SPRITE_FSM_PALETTE_OUT_EN
    logic [31:0] r_palette;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_palette <= '0;
        else if (r_state == GET_X)
            r_palette[{r_idx, 2'b00} +: 4] <= sprite_RAM_din[3:0];
    end

    assign palette_out = r_palette;
`else
    assign palette_out = '0;
`endif

endmodule

// File: tb/tb_sprite_fsm.sv
// Directed self-checking bench for sprite_fsm with a one-cycle registered sprite RAM model.
// Palette expectations follow SPRITE_FSM_PALETTE_OUT_EN.
`timescale 1ns/1ps
module tb_sprite_fsm;

    logic        clk;
    logic        rst;
    logic        vblank;
    logic [7:0]  sprite_RAM_din;
    logic        rd_en;
    logic [15:0] sprite_RAM_addr;
    logic [7:0]  fsm_dout;
    logic [7:0]  ld_palette;
    logic [7:0]  ld_x;
    logic [7:0]  ld_y;
    logic [7:0]  ld_num_flips;
    logic [31:0] palette_out;

    int checks = 0;
    int errors = 0;
    int ram_mode = 0;

    sprite_fsm dut (
        .clk             (clk),
        .rst             (rst),
        .vblank          (vblank),
        .sprite_RAM_din  (sprite_RAM_din),
        .rd_en           (rd_en),
        .sprite_RAM_addr (sprite_RAM_addr),
        .fsm_dout        (fsm_dout),
        .ld_palette      (ld_palette),
        .ld_x            (ld_x),
        .ld_y            (ld_y),
        .ld_num_flips    (ld_num_flips),
        .palette_out     (palette_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: every byte is FF. Mode 1: palette bytes are 10+i, others addr^5A.
    function automatic logic [7:0] ram_data(input logic [15:0] a, input int mode);
        logic [15:0] d;
        if (mode == 0)
            return 8'hFF;
        if (a >= 16'h4FF1 && a <= 16'h4FFF && a[0]) begin
            d = (a - 16'h4FF1) >> 1;
            return 8'h10 + d[7:0];
        end
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk)
        sprite_RAM_din <= rd_en ? ram_data(sprite_RAM_addr, ram_mode) : 8'h00;

    task automatic test_reset();
        rst    = 1'b1;
        vblank = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (rd_en !== 1'b0 || sprite_RAM_addr !== 16'h0000) begin
                errors++;
                $display("FAIL reset_bus cyc=%0d: rd_en=%b addr=%h, expected rd_en=0 addr=0000", k, rd_en, sprite_RAM_addr);
            end
            checks++;
            if ({ld_palette, ld_x, ld_y, ld_num_flips} !== 32'h0) begin
                errors++;
                $display("FAIL reset_strobes cyc=%0d: got %h, expected 00000000", k,
                         {ld_palette, ld_x, ld_y, ld_num_flips});
            end
            checks++;
            if (palette_out !== 32'h0) begin
                errors++;
                $display("FAIL reset_palette cyc=%0d: got %h, expected 00000000", k, palette_out);
            end
        end
    endtask

    // Starts at a negedge with the FSM idle and vblank low. hold = extra DONE cycles with vblank high.
    // drop_at / rst_at: pass cycle index at which vblank drops / rst fires (99 = never).
    task automatic test_pass(input int mode, input int hold, input int drop_at, input int rst_at);
        logic [15:0] exp_addr;
        logic [15:0] prev_addr;
        logic [31:0] exp_strb;
        logic [7:0]  onehot;
        logic [15:0] off;
        int s;
        int p;
        ram_mode  = mode;
        vblank    = 1'b1;
        prev_addr = 16'h0;
        @(negedge clk);
        for (int unsigned k = 0; k < 40; k++) begin
            s        = int'(k) / 5;
            p        = int'(k) % 5;
            off      = 16'(2 * s);
            onehot   = 8'b0000_0001 << s;
            exp_addr = 16'h0000;
            exp_strb = 32'h0;
            case (p)
                0: exp_addr = 16'h4FF1 + off;
                1: begin exp_addr = 16'h5060 + off; exp_strb = {onehot, 24'h0}; end
                2: begin exp_addr = 16'h5061 + off; exp_strb = {8'h0, onehot, 16'h0}; end
                3: begin exp_addr = 16'h4FF0 + off; exp_strb = {16'h0, onehot, 8'h0}; end
                default: exp_strb = {24'h0, onehot};
            endcase
            checks++;
            if (rd_en !== (p != 4) || sprite_RAM_addr !== exp_addr) begin
                errors++;
                $display("FAIL pass_addr s=%0d p=%0d: rd_en=%b addr=%h, expected rd_en=%b addr=%h",
                         s, p, rd_en, sprite_RAM_addr, p != 4, exp_addr);
            end
            checks++;
            if ({ld_palette, ld_x, ld_y, ld_num_flips} !== exp_strb) begin
                errors++;
                $display("FAIL pass_strobe s=%0d p=%0d: got %h, expected %h", s, p,
                         {ld_palette, ld_x, ld_y, ld_num_flips}, exp_strb);
            end
            if (p != 0) begin
                checks++;
                if (fsm_dout !== ram_data(prev_addr, mode)) begin
                    errors++;
                    $display("FAIL pass_dout s=%0d p=%0d: got %h, expected %h", s, p, fsm_dout,
                             ram_data(prev_addr, mode));
                end
            end
            if (int'(k) == rst_at) begin
                #1 rst = 1'b1;
                #1;
                checks++;
                if (rd_en !== 1'b0 || sprite_RAM_addr !== 16'h0000 ||
                    {ld_palette, ld_x, ld_y, ld_num_flips} !== 32'h0 || palette_out !== 32'h0) begin
                    errors++;
                    $display("FAIL midpass_reset: rd_en=%b addr=%h strobes=%h pal=%h, expected all zero",
                             rd_en, sprite_RAM_addr, {ld_palette, ld_x, ld_y, ld_num_flips}, palette_out);
                end
                vblank = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (int'(k) == drop_at)
                vblank = 1'b0;
            prev_addr = exp_addr;
            @(negedge clk);
        end
        for (int unsigned h = 0; h <= 32'(hold); h++) begin
            checks++;
            if (rd_en !== 1'b0 || sprite_RAM_addr !== 16'h0000 ||
                {ld_palette, ld_x, ld_y, ld_num_flips} !== 32'h0) begin
                errors++;
                $display("FAIL done_park h=%0d: rd_en=%b addr=%h strobes=%h, expected all zero",
                         h, rd_en, sprite_RAM_addr, {ld_palette, ld_x, ld_y, ld_num_flips});
            end
            if (h != 32'(hold))
                @(negedge clk);
        end
        vblank = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: rd_en=%b, expected 0", rd_en);
        end
    endtask

    task automatic test_full_pass();
        test_pass(0, 10, 99, 99);
        checks++;
`ifdef SPRITE_FSM_PALETTE_OUT_EN
        if (palette_out !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL palette_ff: got %h, expected ffffffff", palette_out);
        end
`else
        if (palette_out !== 32'h00000000) begin
            errors++;
            $display("FAIL palette_ff: got %h, expected 00000000", palette_out);
        end
`endif
    endtask

    task automatic test_palette();
        test_pass(1, 2, 99, 99);
        checks++;
`ifdef SPRITE_FSM_PALETTE_OUT_EN
        if (palette_out !== 32'h76543210) begin
            errors++;
            $display("FAIL palette_pack: got %h, expected 76543210", palette_out);
        end
`else
        if (palette_out !== 32'h00000000) begin
            errors++;
            $display("FAIL palette_pack: got %h, expected 00000000", palette_out);
        end
`endif
    endtask

    task automatic test_vblank_drop();
        test_pass(1, 0, 17, 99);
        test_pass(0, 3, 99, 99);
    endtask

    task automatic test_reset_midpass();
        test_pass(1, 0, 99, 27);
        test_pass(1, 1, 99, 99);
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_palette();
        test_vblank_drop();
        test_reset_midpass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
